// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: default sizes and the count-width helper for dff_pipe
package dff_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one W-bit register with async active-low reset, enable and sync clear to RST
// Ports: clk, reset (async, active low), en (load d), clr (sync clear, wins over en), d, q
module dff_stage #(
  parameter int W = 9,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q, r_d;
  assign r_d = clr ? RST : en ? d : r_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= RST;
    else r_q <= r_d;
  assign q = r_q;
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled/flushable data pipeline with per-word valid and occupancy count
// Ports: clk; reset (async, active low); en (advance); flush (sync clear, wins over en);
//        d/d_valid (stage 0 input); q/q_valid (last stage); qb (~q); count (valid words held)
// Build option: define DFF_PIPE_ASSERT_EN to compile in concurrent assertions.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qb,
  output logic                       q_valid,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int CW = cnt_w(DEPTH);
  // each stage packs {data, valid}; valid is bit 0
  logic [WIDTH:0] s_q [DEPTH];
  logic [WIDTH:0] s_d [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign s_d[g] = {d, d_valid};
    end else begin : g_body
      assign s_d[g] = s_q[g-1];
    end
    dff_stage #(.W(WIDTH + 1), .RST({RESET_VAL, 1'b0})) u_stage (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .clr  (flush),
      .d    (s_d[g]),
      .q    (s_q[g])
    );
  end
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(s_q[i][0]);
  end
  assign q       = s_q[DEPTH-1][WIDTH:1];
  assign q_valid = s_q[DEPTH-1][0];
  assign qb      = ~q;
`ifdef DFF_PIPE_ASSERT_EN
  a_qb:    assert property (@(posedge clk) qb == ~q);
  a_cnt:   assert property (@(posedge clk) disable iff (!reset) count <= CW'(DEPTH));
  a_qv:    assert property (@(posedge clk) disable iff (!reset) q_valid |-> count != '0);
  a_flush: assert property (@(posedge clk) disable iff (!reset) flush |=> count == '0);
`endif
endmodule
